// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad conditioner.
// Build option: define KEYPAD_AUTOREPEAT_EN to add the RPT_WAIT autorepeat state.
package keypad_pkg;

   localparam int unsigned NUM_KEYS = 8;

   localparam logic [2:0] KEY_LEFT  = 3'd0;
   localparam logic [2:0] KEY_RIGHT = 3'd1;
   localparam logic [2:0] KEY_DOWN  = 3'd2;
   localparam logic [2:0] KEY_UP    = 3'd3;

   localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
   localparam logic [7:0]  DEF_PULSE_CYCLES    = 8'd8;
   localparam logic [23:0] DEF_REPEAT_DELAY    = 24'd5000000;
   localparam logic [23:0] DEF_REPEAT_PERIOD   = 24'd1000000;

`ifdef KEYPAD_AUTOREPEAT_EN
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PULSE    = 2'd1,
      ST_HOLD     = 2'd2,
      ST_RPT_WAIT = 2'd3
   } kp_state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_HOLD  = 2'd2
   } kp_state_e;
`endif

   // Lowest set index wins when several keys are pressed in the same cycle.
   function automatic logic [2:0] lowest_key(input logic [NUM_KEYS-1:0] keys);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (keys[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_conditioner_debounce.sv
// Single-key synchronizer and debouncer; emits a one-cycle press event on an
// accepted 0->1 change, suppressed for keys that were already down at reset.
module key_debounce
   import keypad_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic stable_o,
   output logic press_o
);

   logic [1:0]  sync_q;
   logic [1:0]  vld_q;
   logic        stable_q, stable_d;
   logic        stable_prev_q;
   logic        armed_q, armed_d;
   logic [15:0] cnt_q, cnt_d;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (sync_q[1] == stable_q) begin
         cnt_d = '0;
      end else if (32'(cnt_q) + 32'd1 >= 32'(DEBOUNCE_CYCLES) - 32'd1) begin
         stable_d = sync_q[1];
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
      // A key arms only once it has been seen released after reset.
      armed_d = armed_q | (vld_q[1] & ~sync_q[1] & ~stable_q);
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q        <= '0;
         vld_q         <= '0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         armed_q       <= 1'b0;
         cnt_q         <= '0;
      end else begin
         sync_q        <= {sync_q[0], raw_i};
         vld_q         <= {vld_q[0], 1'b1};
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
         armed_q       <= armed_d;
         cnt_q         <= cnt_d;
      end
   end

   assign stable_o = stable_q;
   assign press_o  = stable_q & ~stable_prev_q & armed_q;

endmodule

// File: rtl/keypad_conditioner.sv
// Keypad conditioner top: eight debounced keys feed a single-owner pulse FSM.
// Build option: KEYPAD_AUTOREPEAT_EN enables autorepeat through RPT_WAIT.
module keypad_conditioner
   import keypad_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter logic [7:0]  PULSE_CYCLES    = DEF_PULSE_CYCLES,
   parameter logic [23:0] REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter logic [23:0] REPEAT_PERIOD   = DEF_REPEAT_PERIOD
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] raw_keys,
   output logic [7:0] keypad,
   output logic       key_held
);

   logic [7:0] stable_key;
   logic [7:0] press_evt;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk     (clk),
         .rst     (rst),
         .raw_i   (raw_keys[i]),
         .stable_o(stable_key[i]),
         .press_o (press_evt[i])
      );
   end

   kp_state_e  state_q, state_d;
   logic [2:0] active_key_q, active_key_d;
   logic [7:0] pulse_cnt_q, pulse_cnt_d;
   logic [7:0] keypad_q, keypad_d;
   logic       key_held_q, key_held_d;

`ifdef KEYPAD_AUTOREPEAT_EN
   logic [23:0] rpt_cnt_q, rpt_cnt_d;
   logic        rpt_first_q, rpt_first_d;
`else
   logic unused_rpt_params;
   assign unused_rpt_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

   // Movement key indices are decoded by the downstream FSM, not here.
   logic unused_key_map;
   assign unused_key_map = ^{KEY_UP, KEY_DOWN, KEY_RIGHT, KEY_LEFT};

   always_comb begin
      state_d      = state_q;
      active_key_d = active_key_q;
      pulse_cnt_d  = pulse_cnt_q;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt_d    = rpt_cnt_q;
      rpt_first_d  = rpt_first_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (|press_evt) begin
               active_key_d = lowest_key(press_evt);
               pulse_cnt_d  = PULSE_CYCLES - 8'd1;
               state_d      = ST_PULSE;
`ifdef KEYPAD_AUTOREPEAT_EN
               rpt_first_d  = 1'b1;
`endif
            end
         end
         ST_PULSE: begin
            if (pulse_cnt_q == '0) begin
`ifdef KEYPAD_AUTOREPEAT_EN
               state_d     = ST_RPT_WAIT;
               rpt_cnt_d   = rpt_first_q ? (REPEAT_DELAY - 24'd1) : (REPEAT_PERIOD - 24'd1);
               rpt_first_d = 1'b0;
`else
               state_d     = ST_HOLD;
`endif
            end else begin
               pulse_cnt_d = pulse_cnt_q - 8'd1;
            end
         end
         ST_HOLD: begin
            if (!stable_key[active_key_q]) state_d = ST_IDLE;
         end
`ifdef KEYPAD_AUTOREPEAT_EN
         ST_RPT_WAIT: begin
            // Release wins over an expiring repeat timer.
            if (!stable_key[active_key_q]) begin
               state_d = ST_IDLE;
            end else if (rpt_cnt_q == '0) begin
               state_d     = ST_PULSE;
               pulse_cnt_d = PULSE_CYCLES - 8'd1;
            end else begin
               rpt_cnt_d = rpt_cnt_q - 24'd1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      // Outputs follow the current state one cycle later, keeping them registered.
      keypad_d   = (state_q == ST_PULSE) ? (8'd1 << active_key_q) : 8'h00;
      key_held_d = (state_q != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         active_key_q <= '0;
         pulse_cnt_q  <= '0;
         keypad_q     <= 8'h00;
         key_held_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rpt_cnt_q    <= '0;
         rpt_first_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         active_key_q <= active_key_d;
         pulse_cnt_q  <= pulse_cnt_d;
         keypad_q     <= keypad_d;
         key_held_q   <= key_held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
         rpt_cnt_q    <= rpt_cnt_d;
         rpt_first_q  <= rpt_first_d;
`endif
      end
   end

   assign keypad   = keypad_q;
   assign key_held = key_held_q;

endmodule

// File: tb/tb_keypad_conditioner.sv
// Scoreboard bench for keypad_conditioner: an edge-counted reference model
// predicts pulses (value, start edge) and key_held; a monitor checks the DUT.
module tb_keypad_conditioner;

   localparam int D  = 4;
   localparam int P  = 8;
   localparam int RD = 20;
   localparam int RP = 10;
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] raw_keys = 8'h00;
   logic [7:0] keypad;
   logic       key_held;

   keypad_conditioner #(
      .DEBOUNCE_CYCLES(16'(D)),
      .PULSE_CYCLES   (8'(P)),
      .REPEAT_DELAY   (24'(RD)),
      .REPEAT_PERIOD  (24'(RP))
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .raw_keys(raw_keys),
      .keypad  (keypad),
      .key_held(key_held)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0] value;
      int         start;
   } pulse_t;

   typedef enum {M_IDLE, M_PULSE, M_AFTER} mode_e;

   pulse_t     exp_q[$];
   mode_e      mode;
   int         edge_n;
   logic [7:0] hist[$];
   logic [7:0] acc, armed, rise_prev;
   logic       held_exp;
   int         key, pulse_begin, after_begin, gap;
   bit         first_pulse;

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      mode = M_IDLE;
      edge_n = 0;
      hist.delete();
      for (int i = 0; i < D; i++) hist.push_back(8'h00);
      acc = '0;
      armed = '0;
      rise_prev = '0;
      held_exp = 1'b0;
      first_pulse = 1'b0;
      exp_q.delete();
   endtask

   task automatic start_pulse();
      pulse_t p;
      pulse_begin = edge_n;
      mode = M_PULSE;
      p.value = 8'(1 << key);
      p.start = edge_n + 1;
      exp_q.push_back(p);
   endtask

   initial begin
      bit   flip;
      logic old;
      int   sz;
      model_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            model_reset();
         end else begin
            edge_n++;
            held_exp = (mode != M_IDLE);
            case (mode)
               M_IDLE: if (rise_prev != 0) begin
                  key = lowest(rise_prev);
                  first_pulse = 1'b1;
                  start_pulse();
               end
               M_PULSE: if (edge_n - pulse_begin == P) begin
                  mode = M_AFTER;
                  after_begin = edge_n;
                  gap = first_pulse ? RD : RP;
               end
               M_AFTER: begin
                  if (!acc[key]) mode = M_IDLE;
                  else if (AUTO && (edge_n - after_begin == gap)) begin
                     first_pulse = 1'b0;
                     start_pulse();
                  end
               end
               default: mode = M_IDLE;
            endcase
            // Accepted level flips once D-1 consecutive synchronized samples disagree.
            sz = hist.size();
            rise_prev = '0;
            for (int i = 0; i < 8; i++) begin
               flip = 1'b1;
               for (int j = sz - D; j <= sz - 2; j++) if (hist[j][i] == acc[i]) flip = 1'b0;
               old = acc[i];
               if (edge_n >= 3 && hist[sz-2][i] == 1'b0 && !old) armed[i] = 1'b1;
               if (flip) acc[i] = ~old;
               rise_prev[i] = flip & ~old & armed[i];
            end
            hist.push_back(raw_keys);
            if (hist.size() > D + 2) void'(hist.pop_front());
         end
      end
   end

   // ---------------- monitor ----------------
   bit         in_pulse = 1'b0;
   int         plen;
   logic [7:0] pval;
   pulse_t     got;

   initial begin
      forever begin
         @(negedge clk or negedge rst);
         if (!rst) begin
            in_pulse = 1'b0;
         end else begin
            check("key_held", 32'(key_held), 32'(held_exp));
            if (!in_pulse) begin
               if (keypad != 8'h00) begin
                  in_pulse = 1'b1;
                  plen = 1;
                  pval = keypad;
                  if (exp_q.size() == 0) begin
                     check("unexpected_pulse", 32'(keypad), 32'h0);
                  end else begin
                     got = exp_q.pop_front();
                     check("pulse_value", 32'(keypad), 32'(got.value));
                     check("pulse_start_edge", 32'(edge_n), 32'(got.start));
                  end
               end
            end else if (keypad == pval) begin
               plen++;
            end else begin
               check("pulse_length", 32'(plen), 32'(P));
               check("pulse_gap", 32'(keypad), 32'h0);
               in_pulse = 1'b0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic drive(input logic [7:0] v, input int hold);
      raw_keys = v;
      cycles(hold);
   endtask

   initial begin
      bit         seen;
      logic [7:0] v;

      cycles(3);
      check("reset_keypad", 32'(keypad), 32'h0);
      check("reset_key_held", 32'(key_held), 32'h0);

      // Clean press sampled first by edge 1 after reset release.
      @(negedge clk);
      rst = 1'b1;
      drive(8'h04, 40);
      drive(8'h00, 40);

      // Bounce on key 1 never settles long enough.
      for (int i = 0; i < 5; i++) begin
         drive(8'h02, 2);
         drive(8'h00, 2);
      end
      drive(8'h00, 30);

      // Simultaneous presses: lowest index only, the other is dropped.
      drive(8'h0A, 30);
      drive(8'h00, 30);
      drive(8'h08, 30);
      drive(8'h00, 30);

      // New key during hold is dropped and does not fire on return to idle.
      drive(8'h01, 20);
      drive(8'h09, 15);
      drive(8'h08, 30);
      drive(8'h00, 30);
      drive(8'h08, 30);
      drive(8'h00, 40);

      // Reset in the third pulse cycle, key kept held across reset.
      raw_keys = 8'h04;
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         if (keypad != 8'h00) seen = 1'b1;
      end
      check("wait_pulse_before_reset", 32'(seen), 32'h1);
      cycles(2);
      #2 rst = 1'b0;
      #1;
      check("reset_abort_keypad", 32'(keypad), 32'h0);
      check("reset_abort_key_held", 32'(key_held), 32'h0);
      cycles(3);
      rst = 1'b1;
      drive(8'h04, 40);
      drive(8'h00, 30);
      drive(8'h04, 30);
      drive(8'h00, 40);

      // Long hold: autorepeat train or a single pulse depending on the build.
      drive(8'h08, 80);
      drive(8'h00, 40);

      // Randomized key traffic.
      for (int s = 0; s < 40; s++) begin
         v = 8'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) v = v | 8'(8'h10 << $urandom_range(0, 3));
         drive(v, $urandom_range(1, 30));
      end
      drive(8'h00, 60);

      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      check("pulse_closed", 32'(in_pulse), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
